// File: rtl/data_access_unit.sv
// Load/store sequencer between execute and the data memory: single LDR/STR and block LDM/STM,
// registered memory request outputs, load extension and register-file writeback.
module data_access_unit #(
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req,
   input  logic                  op_load,
   input  logic [1:0]            op_size,
   input  logic                  op_signed,
   input  logic                  op_block,
   input  logic                  op_up,
   input  logic [3:0]            rd,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [15:0]           reg_list,
   input  logic [ADDR_WIDTH-1:0] st_data,
   output logic [3:0]            rf_raddr,
   input  logic [ADDR_WIDTH-1:0] rf_rdata,
   output logic [ADDR_WIDTH-1:0] MADD,
   output logic [ADDR_WIDTH-1:0] MDATA,
   output logic [1:0]            mem_type,
   output logic                  RW,
   input  logic [ADDR_WIDTH-1:0] MDOUT,
   output logic                  busy,
   output logic                  done,
   output logic                  align_fault,
   output logic                  wb_en,
   output logic [3:0]            wb_addr,
   output logic [ADDR_WIDTH-1:0] wb_data,
   output logic [ADDR_WIDTH-1:0] next_base
);

   typedef enum logic [1:0] {StIdle, StXfer, StFinish} state_e;

   localparam logic [ADDR_WIDTH-1:0] WordStep = ADDR_WIDTH'(4);

   state_e                  state_q;
   logic [15:0]             regs_q;
   logic [3:0]              cur_q;
   logic [3:0]              rd_q;
   logic                    load_q;
   logic                    signed_q;
   logic                    block_q;
   logic [1:0]              size_q;
   logic [ADDR_WIDTH-1:0]   nb_q;

   logic [4:0]              req_count;
   logic [3:0]              req_first;
   logic [3:0]              rem_first;
   logic [ADDR_WIDTH-1:0]   offset;
   logic [ADDR_WIDTH-1:0]   start_addr;
   logic [ADDR_WIDTH-1:0]   end_base;
   logic                    single_mis;
   logic                    block_mis;

   function automatic logic [3:0] lowest_set(input logic [15:0] v);
      logic [3:0] idx;
      idx = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (v[i]) idx = 4'(i);
      end
      return idx;
   endfunction

   function automatic logic [4:0] popcount(input logic [15:0] v);
      logic [4:0] c;
      c = 5'd0;
      for (int i = 0; i < 16; i++) begin
         c = c + 5'(v[i]);
      end
      return c;
   endfunction

   function automatic logic [ADDR_WIDTH-1:0] extend(input logic [ADDR_WIDTH-1:0] d,
                                                    input logic [1:0] sz, input logic sgn);
      logic [ADDR_WIDTH-1:0] r;
      case (sz)
         2'b00:   r = d;
         2'b01:   r = {{(ADDR_WIDTH-16){sgn & d[15]}}, d[15:0]};
         default: r = {{(ADDR_WIDTH-8){sgn & d[7]}}, d[7:0]};
      endcase
      return r;
   endfunction

   assign req_count  = popcount(reg_list);
   assign req_first  = lowest_set(reg_list);
   assign rem_first  = lowest_set(regs_q);
   assign offset     = {{(ADDR_WIDTH-7){1'b0}}, req_count, 2'b00};
   assign end_base   = op_up ? base_addr + offset : base_addr - offset;
   // Decrement-before starts at the lowest address, which is also the final base.
   assign start_addr = op_up ? base_addr : base_addr - offset;
   assign single_mis = ((op_size == 2'b00) && (base_addr[1:0] != 2'b00)) ||
                       ((op_size == 2'b01) && base_addr[0]);
   assign block_mis  = base_addr[1:0] != 2'b00;

   always_comb begin
      rf_raddr = req_first;
      if (state_q == StXfer) rf_raddr = rem_first;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         regs_q      <= '0;
         cur_q       <= '0;
         rd_q        <= '0;
         load_q      <= 1'b0;
         signed_q    <= 1'b0;
         block_q     <= 1'b0;
         size_q      <= '0;
         nb_q        <= '0;
         MADD        <= '0;
         MDATA       <= '0;
         mem_type    <= '0;
         RW          <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         align_fault <= 1'b0;
         wb_en       <= 1'b0;
         wb_addr     <= '0;
         wb_data     <= '0;
         next_base   <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               done        <= 1'b0;
               align_fault <= 1'b0;
               wb_en       <= 1'b0;
               busy        <= 1'b0;
               if (req) begin
                  if (!op_block) begin
                     if (single_mis) begin
                        state_q     <= StFinish;
                        busy        <= 1'b1;
                        done        <= 1'b1;
                        align_fault <= 1'b1;
                        next_base   <= base_addr;
                     end else begin
                        state_q  <= StXfer;
                        busy     <= 1'b1;
                        MADD     <= base_addr;
                        mem_type <= op_size;
                        RW       <= ~op_load;
                        MDATA    <= st_data;
                        load_q   <= op_load;
                        signed_q <= op_signed;
                        size_q   <= op_size;
                        block_q  <= 1'b0;
                        rd_q     <= rd;
                        regs_q   <= '0;
                        cur_q    <= '0;
                        nb_q     <= base_addr;
                     end
                  end else if (block_mis || (req_count == 5'd0)) begin
                     state_q     <= StFinish;
                     busy        <= 1'b1;
                     done        <= 1'b1;
                     align_fault <= block_mis;
                     next_base   <= base_addr;
                  end else begin
                     state_q  <= StXfer;
                     busy     <= 1'b1;
                     MADD     <= start_addr;
                     mem_type <= 2'b00;
                     RW       <= ~op_load;
                     MDATA    <= rf_rdata;
                     load_q   <= op_load;
                     signed_q <= 1'b0;
                     size_q   <= 2'b00;
                     block_q  <= 1'b1;
                     rd_q     <= rd;
                     cur_q    <= req_first;
                     regs_q   <= reg_list & (reg_list - 16'd1);
                     nb_q     <= end_base;
                  end
               end
            end
            StXfer: begin
               wb_en <= load_q;
               if (load_q) begin
                  wb_addr <= block_q ? cur_q : rd_q;
                  wb_data <= extend(MDOUT, size_q, signed_q);
               end
               if (regs_q != 16'd0) begin
                  MADD   <= MADD + WordStep;
                  cur_q  <= rem_first;
                  regs_q <= regs_q & (regs_q - 16'd1);
                  if (!load_q) MDATA <= rf_rdata;
               end else begin
                  state_q   <= StFinish;
                  RW        <= 1'b0;
                  done      <= 1'b1;
                  next_base <= nb_q;
               end
            end
            StFinish: begin
               state_q     <= StIdle;
               busy        <= 1'b0;
               done        <= 1'b0;
               align_fault <= 1'b0;
               wb_en       <= 1'b0;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_data_access_unit.sv
// Directed bench for data_access_unit: table of single loads/stores plus block, reset and wrap
// sequences, against a byte-array memory and a register-file model.
module tb_data_access_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        req;
   logic        op_load;
   logic [1:0]  op_size;
   logic        op_signed;
   logic        op_block;
   logic        op_up;
   logic [3:0]  rd;
   logic [31:0] base_addr;
   logic [15:0] reg_list;
   logic [31:0] st_data;
   logic [3:0]  rf_raddr;
   logic [31:0] rf_rdata;
   logic [31:0] MADD;
   logic [31:0] MDATA;
   logic [1:0]  mem_type;
   logic        RW;
   logic [31:0] MDOUT;
   logic        busy;
   logic        done;
   logic        align_fault;
   logic        wb_en;
   logic [3:0]  wb_addr;
   logic [31:0] wb_data;
   logic [31:0] next_base;

   logic [7:0]  mem [0:63];
   logic [31:0] rf  [0:15];
   logic [5:0]  ma;

   always #5 clk = ~clk;

   // Memory returns the little-endian word starting at MADD; the unit must pick the low bytes.
   assign ma       = MADD[5:0];
   assign MDOUT    = {mem[ma + 6'd3], mem[ma + 6'd2], mem[ma + 6'd1], mem[ma]};
   assign rf_rdata = rf[rf_raddr];

   data_access_unit #(.ADDR_WIDTH(32)) dut (
      .clk(clk), .reset(reset), .req(req), .op_load(op_load), .op_size(op_size),
      .op_signed(op_signed), .op_block(op_block), .op_up(op_up), .rd(rd),
      .base_addr(base_addr), .reg_list(reg_list), .st_data(st_data), .rf_raddr(rf_raddr),
      .rf_rdata(rf_rdata), .MADD(MADD), .MDATA(MDATA), .mem_type(mem_type), .RW(RW),
      .MDOUT(MDOUT), .busy(busy), .done(done), .align_fault(align_fault), .wb_en(wb_en),
      .wb_addr(wb_addr), .wb_data(wb_data), .next_base(next_base)
   );

   int total = 0;
   int bad   = 0;

   int          t_done_cyc, t_rw_cnt, t_wb_n, t_acc_n;
   logic        t_fault, t_busy1;
   logic [31:0] t_nb;
   logic [31:0] t_acc_addr [0:7];
   logic [31:0] t_acc_data [0:7];
   logic [1:0]  t_acc_type [0:7];
   int          t_acc_cyc  [0:7];
   logic [3:0]  t_wb_addr  [0:7];
   logic [31:0] t_wb_data  [0:7];
   int          t_wb_cyc   [0:7];

   typedef struct {
      logic        load;
      logic [31:0] addr;
      logic [1:0]  size;
      logic        sgn;
      logic [3:0]  rd;
      logic [31:0] data;   // expected writeback for loads, store data for stores
      logic        fault;
   } vec_t;

   vec_t vecs [0:13];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Called at a negedge in IDLE with inputs set; returns one idle cycle after completion.
   task automatic run_txn();
      t_done_cyc = 0; t_rw_cnt = 0; t_wb_n = 0; t_acc_n = 0;
      t_fault = 1'b0; t_busy1 = 1'b0; t_nb = '0;
      req = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (k == 1) begin
            req = 1'b0;
            t_busy1 = busy;
         end
         if (RW) t_rw_cnt++;
         if (busy && !done && t_acc_n < 8) begin
            t_acc_addr[t_acc_n] = MADD;
            t_acc_data[t_acc_n] = MDATA;
            t_acc_type[t_acc_n] = mem_type;
            t_acc_cyc[t_acc_n]  = k;
            t_acc_n++;
         end
         if (wb_en && t_wb_n < 8) begin
            t_wb_addr[t_wb_n] = wb_addr;
            t_wb_data[t_wb_n] = wb_data;
            t_wb_cyc[t_wb_n]  = k;
            t_wb_n++;
         end
         if (done) begin
            t_done_cyc = k;
            t_fault    = align_fault;
            t_nb       = next_base;
            break;
         end
      end
      @(negedge clk);
   endtask

   task automatic set_block(input logic ld, input logic up, input logic [31:0] base,
                            input logic [15:0] list);
      op_load = ld; op_block = 1'b1; op_up = up; base_addr = base; reg_list = list;
      op_size = 2'b00; op_signed = 1'b0; rd = 4'd0; st_data = '0;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 8'h00;
      for (int i = 0; i < 16; i++) rf[i] = 32'h0;
      mem[6'h04] = 8'h11; mem[6'h05] = 8'h22; mem[6'h06] = 8'h33; mem[6'h07] = 8'h44;
      mem[6'h08] = 8'h34; mem[6'h09] = 8'h92; mem[6'h0A] = 8'h77; mem[6'h0B] = 8'h66;
      mem[6'h0C] = 8'h01; mem[6'h0D] = 8'h02; mem[6'h0E] = 8'h03; mem[6'h0F] = 8'h04;
      mem[6'h10] = 8'h80; mem[6'h11] = 8'h55; mem[6'h12] = 8'hAA; mem[6'h13] = 8'h12;

      vecs[0]  = '{1'b1, 32'h10, 2'b10, 1'b1, 4'd3,  32'hFFFFFF80, 1'b0};
      vecs[1]  = '{1'b1, 32'h10, 2'b10, 1'b0, 4'd3,  32'h00000080, 1'b0};
      vecs[2]  = '{1'b1, 32'h02, 2'b00, 1'b0, 4'd1,  32'h0,        1'b1};
      vecs[3]  = '{1'b1, 32'h04, 2'b00, 1'b0, 4'd5,  32'h44332211, 1'b0};
      vecs[4]  = '{1'b1, 32'h08, 2'b01, 1'b1, 4'd7,  32'hFFFF9234, 1'b0};
      vecs[5]  = '{1'b1, 32'h08, 2'b01, 1'b0, 4'd8,  32'h00009234, 1'b0};
      vecs[6]  = '{1'b1, 32'h09, 2'b01, 1'b1, 4'd2,  32'h0,        1'b1};
      vecs[7]  = '{1'b1, 32'h12, 2'b10, 1'b1, 4'd15, 32'hFFFFFFAA, 1'b0};
      vecs[8]  = '{1'b1, 32'h10, 2'b11, 1'b1, 4'd2,  32'hFFFFFF80, 1'b0};
      vecs[9]  = '{1'b1, 32'h11, 2'b10, 1'b0, 4'd4,  32'h00000055, 1'b0};
      vecs[10] = '{1'b1, 32'h10, 2'b00, 1'b1, 4'd9,  32'h12AA5580, 1'b0};
      vecs[11] = '{1'b1, 32'h10, 2'b01, 1'b1, 4'd6,  32'h00005580, 1'b0};
      vecs[12] = '{1'b0, 32'h20, 2'b00, 1'b0, 4'd0,  32'hDEADBEEF, 1'b0};
      vecs[13] = '{1'b0, 32'h23, 2'b01, 1'b0, 4'd0,  32'h00001234, 1'b1};

      reset = 1'b1; req = 1'b0; op_load = 1'b0; op_size = 2'b00; op_signed = 1'b0;
      op_block = 1'b0; op_up = 1'b0; rd = 4'd0; base_addr = '0; reg_list = '0; st_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_madd", MADD, 32'h0);
      chk("rst_mdata", MDATA, 32'h0);
      chk("rst_type", {30'd0, mem_type}, 32'h0);
      chk("rst_rw", {31'd0, RW}, 32'h0);
      chk("rst_busy", {31'd0, busy}, 32'h0);
      chk("rst_done", {31'd0, done}, 32'h0);
      chk("rst_fault", {31'd0, align_fault}, 32'h0);
      chk("rst_wb_en", {31'd0, wb_en}, 32'h0);
      chk("rst_wb_data", wb_data, 32'h0);
      chk("rst_next_base", next_base, 32'h0);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 14; i++) begin
         op_load = vecs[i].load; op_size = vecs[i].size; op_signed = vecs[i].sgn;
         op_block = 1'b0; op_up = 1'b0; rd = vecs[i].rd; base_addr = vecs[i].addr;
         reg_list = 16'h0; st_data = vecs[i].data;
         run_txn();
         chk($sformatf("v%0d_done_cycle", i), t_done_cyc, vecs[i].fault ? 1 : 2);
         chk($sformatf("v%0d_fault", i), {31'd0, t_fault}, {31'd0, vecs[i].fault});
         chk($sformatf("v%0d_rw_cycles", i), t_rw_cnt,
             (!vecs[i].load && !vecs[i].fault) ? 1 : 0);
         chk($sformatf("v%0d_wb_count", i), t_wb_n,
             (vecs[i].load && !vecs[i].fault) ? 1 : 0);
         chk($sformatf("v%0d_access_count", i), t_acc_n, vecs[i].fault ? 0 : 1);
         if (!vecs[i].fault && t_acc_n > 0) begin
            chk($sformatf("v%0d_madd", i), t_acc_addr[0], vecs[i].addr);
            chk($sformatf("v%0d_type", i), {30'd0, t_acc_type[0]}, {30'd0, vecs[i].size});
            if (!vecs[i].load) chk($sformatf("v%0d_mdata", i), t_acc_data[0], vecs[i].data);
         end
         if (vecs[i].load && !vecs[i].fault && t_wb_n > 0) begin
            chk($sformatf("v%0d_wb_addr", i), {28'd0, t_wb_addr[0]}, {28'd0, vecs[i].rd});
            chk($sformatf("v%0d_wb_data", i), t_wb_data[0], vecs[i].data);
            chk($sformatf("v%0d_wb_cycle", i), t_wb_cyc[0], 2);
         end
      end

      // STM increment-after, r0/r1/r4.
      rf[0] = 32'hA; rf[1] = 32'hB; rf[4] = 32'hC;
      set_block(1'b0, 1'b1, 32'h0, 16'h0013);
      run_txn();
      chk("stm_busy", {31'd0, t_busy1}, 32'h1);
      chk("stm_acc_n", t_acc_n, 3);
      chk("stm_rw_cycles", t_rw_cnt, 3);
      for (int j = 0; j < 3; j++) begin
         if (j < t_acc_n) begin
            chk($sformatf("stm_addr%0d", j), t_acc_addr[j], 32'(4 * j));
            chk($sformatf("stm_data%0d", j), t_acc_data[j], 32'hA + 32'(j));
            chk($sformatf("stm_cyc%0d", j), t_acc_cyc[j], j + 1);
         end
      end
      chk("stm_done_cycle", t_done_cyc, 4);
      chk("stm_next_base", t_nb, 32'hC);
      chk("stm_wb_count", t_wb_n, 0);

      // LDM decrement-before, r0 and r15.
      set_block(1'b1, 1'b0, 32'h10, 16'h8001);
      run_txn();
      chk("ldm_acc_n", t_acc_n, 2);
      if (t_acc_n == 2) begin
         chk("ldm_addr0", t_acc_addr[0], 32'h8);
         chk("ldm_addr1", t_acc_addr[1], 32'hC);
      end
      chk("ldm_rw_cycles", t_rw_cnt, 0);
      chk("ldm_wb_count", t_wb_n, 2);
      if (t_wb_n == 2) begin
         chk("ldm_wb0_addr", {28'd0, t_wb_addr[0]}, 32'd0);
         chk("ldm_wb0_data", t_wb_data[0], 32'h66779234);
         chk("ldm_wb0_cyc", t_wb_cyc[0], 2);
         chk("ldm_wb1_addr", {28'd0, t_wb_addr[1]}, 32'd15);
         chk("ldm_wb1_data", t_wb_data[1], 32'h04030201);
         chk("ldm_wb1_cyc", t_wb_cyc[1], 3);
      end
      chk("ldm_done_cycle", t_done_cyc, 3);
      chk("ldm_next_base", t_nb, 32'h8);

      // Reset during the second XFER cycle of a 4-register STM.
      rf[4] = 32'h44; rf[5] = 32'h55; rf[6] = 32'h66; rf[7] = 32'h77;
      set_block(1'b0, 1'b1, 32'h20, 16'h00F0);
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      chk("rst_mid_xfer1_rw", {31'd0, RW}, 32'h1);
      @(negedge clk);
      chk("rst_mid_xfer2_madd", MADD, 32'h24);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rst_mid_rw", {31'd0, RW}, 32'h0);
      chk("rst_mid_busy", {31'd0, busy}, 32'h0);
      chk("rst_mid_done", {31'd0, done}, 32'h0);
      chk("rst_mid_madd", MADD, 32'h0);
      @(negedge clk);
      chk("rst_mid_done_after", {31'd0, done}, 32'h0);
      op_load = 1'b1; op_size = 2'b00; op_signed = 1'b0; op_block = 1'b0; rd = 4'd6;
      base_addr = 32'h4;
      run_txn();
      chk("post_rst_done_cycle", t_done_cyc, 2);
      chk("post_rst_wb_data", t_wb_n > 0 ? t_wb_data[0] : 32'hX, 32'h44332211);

      // Empty block list.
      set_block(1'b1, 1'b1, 32'h40, 16'h0000);
      run_txn();
      chk("empty_done_cycle", t_done_cyc, 1);
      chk("empty_acc_n", t_acc_n, 0);
      chk("empty_next_base", t_nb, 32'h40);
      chk("empty_fault", {31'd0, t_fault}, 32'h0);

      // Misaligned block base.
      set_block(1'b1, 1'b1, 32'h2, 16'h0001);
      run_txn();
      chk("blk_mis_done_cycle", t_done_cyc, 1);
      chk("blk_mis_fault", {31'd0, t_fault}, 32'h1);
      chk("blk_mis_acc_n", t_acc_n, 0);

      // Address wrap at the top of the space.
      rf[0] = 32'h11111111; rf[1] = 32'h22222222;
      set_block(1'b0, 1'b1, 32'hFFFFFFFC, 16'h0003);
      run_txn();
      chk("wrap_acc_n", t_acc_n, 2);
      if (t_acc_n == 2) begin
         chk("wrap_addr0", t_acc_addr[0], 32'hFFFFFFFC);
         chk("wrap_addr1", t_acc_addr[1], 32'h0);
         chk("wrap_data0", t_acc_data[0], 32'h11111111);
         chk("wrap_data1", t_acc_data[1], 32'h22222222);
      end
      chk("wrap_done_cycle", t_done_cyc, 3);
      chk("wrap_next_base", t_nb, 32'h4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
